// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI responder front end
package spi_pkg;
  localparam int SPI_DATA_WIDTH = 8;
  localparam logic [7:0] CMD_START = 8'h00;
  localparam logic [7:0] CMD_RUN = 8'hFF;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_state_t;
endpackage

// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: SPI pins plus the byte-level rx/tx handshake of the responder
interface spi_slave_if_if
  import spi_pkg::*;
#(
  parameter int W = SPI_DATA_WIDTH
);
  logic SCK, SS, MOSI, MISO;
  logic [W-1:0] rx_data, tx_data;
  logic rx_valid, tx_load, tx_pending, frame_err;
  modport slave (
    input SCK, SS, MOSI, tx_data, tx_load,
    output MISO, rx_data, rx_valid, tx_pending, frame_err
  );
  modport master (
    output SCK, SS, MOSI, tx_data, tx_load,
    input MISO, rx_data, rx_valid, tx_pending, frame_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall detection on the last stage
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES:0] vld_q;
  logic prev_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      vld_q  <= {vld_q[STAGES-1:0], 1'b1};
    end
  end
  assign q_o = sync_q[STAGES-1];
  // Edges are suppressed until the chain holds real samples, so a line that was
  // already active at reset release is not mistaken for a fresh transition.
  assign rise_o = vld_q[STAGES] & q_o & ~prev_q;
  assign fall_o = vld_q[STAGES] & ~q_o & prev_q;
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI responder - oversampled SCK/SS/MOSI, LSB-first rx/tx byte shifters
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL = '1
) (
  input logic clk,
  input logic n_rst,
  spi_slave_if_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  spi_state_t state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d, holding_q, holding_d;
  logic miso_q, miso_d, rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, pending_q, pending_d;
  logic sck_s, sck_r, sck_f, ss_s, ss_r, ss_f, mosi_s, mosi_r, mosi_f;
  logic unused_sync;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .n_rst(n_rst), .d_i(bus.SCK), .q_o(sck_s), .rise_o(sck_r), .fall_o(sck_f));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .n_rst(n_rst), .d_i(bus.SS), .q_o(ss_s), .rise_o(ss_r), .fall_o(ss_f));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_mosi (
    .clk(clk), .n_rst(n_rst), .d_i(bus.MOSI), .q_o(mosi_s), .rise_o(mosi_r), .fall_o(mosi_f));
  assign unused_sync = ^{sck_s, ss_s, mosi_r, mosi_f};
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= IDLE_FILL;
      rx_data_q   <= '0;
      holding_q   <= IDLE_FILL;
      miso_q      <= 1'b1;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      holding_q   <= holding_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      pending_q   <= pending_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    holding_d   = bus.tx_load ? bus.tx_data : holding_q;
    // A load landing in the LOAD cycle survives as the next pending byte.
    pending_d   = bus.tx_load | (pending_q & (state_q != LOAD));
    unique case (state_q)
      IDLE: begin
        miso_d  = 1'b1;
        state_d = ss_f ? LOAD : IDLE;
      end
      LOAD: begin
        tx_shift_d = pending_q ? holding_q : IDLE_FILL;
        miso_d     = tx_shift_d[0];
        bit_cnt_d  = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (ss_r) begin
          frame_err_d = bit_cnt_q != '0;
          miso_d      = 1'b1;
          state_d     = IDLE;
        end else if (sck_r) begin
          rx_shift_d = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d  = (bit_cnt_q == LAST) ? bit_cnt_q : bit_cnt_q + 1'b1;
          state_d    = (bit_cnt_q == LAST) ? DONE : SHIFT;
        end else if (sck_f && bit_cnt_q != '0) begin
          tx_shift_d = {1'b1, tx_shift_q[DATA_WIDTH-1:1]};
          miso_d     = tx_shift_q[1];
        end
      end
      DONE: begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        miso_d     = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end
  assign bus.MISO       = miso_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_pending = pending_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: randomized host frames against a byte-level model with an rx scoreboard
module tb_spi_slave_if;
  import spi_pkg::*;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  spi_slave_if_if bus ();
  spi_slave_if dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));
  always #2 clk = ~clk;
  int n_cmp = 0, n_bad = 0, ferr_seen = 0, ferr_exp = 0;
  logic [7:0] exp_q[$];
  logic model_pend = 1'b0;
  logic [7:0] model_hold = 8'hFF;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.rx_valid) begin
        if (exp_q.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
        else check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (bus.frame_err) ferr_seen++;
    end
  end
  task automatic tx_load(input logic [7:0] v);
    @(negedge clk);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    model_hold = v;
    model_pend = 1'b1;
  endtask
  task automatic sck_bit(input logic b, output logic r);
    bus.MOSI = b;
    #41 bus.SCK = 1'b1;
    r = bus.MISO;
    #42 bus.SCK = 1'b0;
  endtask
  task automatic frame(input logic [7:0] tx, input int nbits, output logic [7:0] rd);
    rd = 8'hFF;
    bus.SS = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) sck_bit(tx[i], rd[i]);
    #50 bus.SS = 1'b1;
    bus.MOSI = 1'b1;
    #100;
  endtask
  task automatic full_frame(input string name, input logic [7:0] tx);
    logic [7:0] rd, exp_rd;
    exp_rd = model_pend ? model_hold : 8'hFF;
    model_pend = 1'b0;
    exp_q.push_back(tx);
    frame(tx, 8, rd);
    check(name, {24'd0, rd}, {24'd0, exp_rd});
  endtask
  initial begin
    logic [7:0] rd, v;
    bus.SCK = 1'b0; bus.SS = 1'b1; bus.MOSI = 1'b1; bus.tx_data = '0; bus.tx_load = 1'b0;
    #23 n_rst = 1'b1;
    @(negedge clk);
    check("reset_miso", {31'd0, bus.MISO}, 32'd1);
    check("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("reset_tx_pending", {31'd0, bus.tx_pending}, 32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    #50;
    full_frame("read_idle_a5", 8'hA5);
    full_frame("read_start", CMD_START);
    for (int i = 0; i < 72; i++) full_frame("read_pixel", 8'($urandom_range(0, 255)));
    full_frame("read_run", CMD_RUN);
    tx_load(8'h07);
    check("pending_after_load", {31'd0, bus.tx_pending}, 32'd1);
    check("miso_ss_high", {31'd0, bus.MISO}, 32'd1);
    full_frame("read_digit", 8'hFF);
    check("pending_after_read", {31'd0, bus.tx_pending}, 32'd0);
    tx_load(8'h5A);
    tx_load(8'hC3);
    full_frame("read_last_wins", 8'hFF);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) tx_load(8'($urandom_range(0, 255)));
      full_frame("read_random", 8'($urandom_range(0, 255)));
    end
    v = 8'($urandom_range(0, 255));
    frame(v, 5, rd);
    ferr_exp++;
    check("frame_err_count", ferr_seen, ferr_exp);
    full_frame("read_after_abort", 8'h3C);
    check("rx_after_abort", {24'd0, bus.rx_data}, 32'h3C);
    bus.SS = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) sck_bit(v[i] | (i == 0), rd[i]);
    #7 n_rst = 1'b0;
    #9;
    check("midrst_miso", {31'd0, bus.MISO}, 32'd1);
    check("midrst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("midrst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    #5 n_rst = 1'b1;
    for (int i = 4; i < 8; i++) sck_bit(i == 7, rd[i]);
    #50 bus.SS = 1'b1;
    #100;
    check("ignored_after_reset_rx", {24'd0, bus.rx_data}, 32'd0);
    check("ignored_after_reset_ferr", ferr_seen, ferr_exp);
    full_frame("read_81", 8'h81);
    check("rx_81", {24'd0, bus.rx_data}, 32'h81);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("rx_outstanding", exp_q.size(), 0);
    check("frame_err_final", ferr_seen, ferr_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
